// File: rtl/input_cond_pkg.sv
// Shared definitions for the push-button / switch input conditioner.
// Also exports the ALU operation encoding used by the lab control FSM.
package input_cond_pkg;

    localparam int unsigned N_ALU_BTN = 4;
    localparam int unsigned N_SW      = 2;

    localparam logic [N_ALU_BTN-1:0] ALU_SEL_RESET = 4'b0001;

    typedef enum logic [1:0] {
        ALU_OR  = 2'b00,
        ALU_AND = 2'b01,
        ALU_SUB = 2'b10,
        ALU_ADD = 2'b11
    } alu_op_t;

    // Isolate the lowest set bit (lowest index wins on simultaneous presses).
    function automatic logic [N_ALU_BTN-1:0] lowest_onehot(input logic [N_ALU_BTN-1:0] v);
        return v & (~v + N_ALU_BTN'(1));
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Bundle of raw board inputs and conditioned outputs of input_conditioner.
//   slave  : the conditioner (consumes raw, drives conditioned outputs)
//   master : the board/stimulus side (drives raw, observes outputs)
interface input_conditioner_if;
    import input_cond_pkg::*;

    logic [N_ALU_BTN-1:0] alu_btn_raw;
    logic                 mode_btn_raw;
    logic [N_SW-1:0]      sw_raw;

    logic [N_ALU_BTN-1:0] alu_btn_lvl;
    logic [N_ALU_BTN-1:0] alu_btn_pulse;
    logic [N_ALU_BTN-1:0] alu_sel;
    logic                 mode_pulse;
    logic                 mode_long;
    logic [N_SW-1:0]      sw_out;

    modport slave (
        input  alu_btn_raw, mode_btn_raw, sw_raw,
        output alu_btn_lvl, alu_btn_pulse, alu_sel, mode_pulse, mode_long, sw_out
    );

    modport master (
        output alu_btn_raw, mode_btn_raw, sw_raw,
        input  alu_btn_lvl, alu_btn_pulse, alu_sel, mode_pulse, mode_long, sw_out
    );

endinterface

// File: rtl/input_conditioner_debounce_ch.sv
// debounce_ch: one input channel -- 2-FF synchroniser, counting debouncer,
// registered debounced level and a one-cycle rising-edge pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : asynchronous raw input bit
//   lvl        : debounced level (registered copy of the stable state)
//   pulse      : one-cycle pulse on each debounced rising edge
module debounce_ch #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic lvl,
    output logic pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             q;
    logic [CNT_W-1:0] cnt;
    logic             lvl_prev;

    // Metastability synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it differs from q for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= 1'b0;
            cnt <= '0;
        end else if (sync2 == q) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            q   <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered level, then rise detect on that level (falling edges give nothing).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl      <= 1'b0;
            lvl_prev <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            lvl      <= q;
            lvl_prev <= lvl;
            pulse    <= lvl & ~lvl_prev;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces the four ALU buttons, the mode
// button and the two slide switches feeding the lab control FSM.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : input_conditioner_if.slave
//                raw: alu_btn_raw[3:0] (OR,AND,SUB,ADD), mode_btn_raw, sw_raw[1:0]
//                out: alu_btn_lvl, alu_btn_pulse, alu_sel (sticky one-hot),
//                     mode_pulse, mode_long, sw_out
// Optional feature: define INPUT_COND_LONGPRESS_EN to enable the mode long-press
// pulse; otherwise mode_long is tied low.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = 100000,
    parameter int unsigned LONGPRESS_CYCLES = 50000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input_conditioner_if.slave  bus
);

    localparam int unsigned MODE_CH = N_ALU_BTN;
    localparam int unsigned SW_LSB  = N_ALU_BTN + 1;
    localparam int unsigned N_CH    = N_ALU_BTN + 1 + N_SW;

    logic [N_CH-1:0]      raw_v;
    logic [N_CH-1:0]      lvl_v;
    logic [N_CH-1:0]      pulse_v;
    logic [N_SW-1:0]      sw_pulse_unused;
    logic [N_ALU_BTN-1:0] alu_pulse;
    logic [N_ALU_BTN-1:0] alu_sel_q;

    assign raw_v = {bus.sw_raw, bus.mode_btn_raw, bus.alu_btn_raw};

    // One independent channel per input bit.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_v[i]),
            .lvl   (lvl_v[i]),
            .pulse (pulse_v[i])
        );
    end

    // Switches are levels only; their edge pulses are not used.
    assign sw_pulse_unused = pulse_v[SW_LSB +: N_SW];

    assign alu_pulse         = pulse_v[N_ALU_BTN-1:0];
    assign bus.alu_btn_lvl   = lvl_v[N_ALU_BTN-1:0];
    assign bus.alu_btn_pulse = alu_pulse;
    assign bus.mode_pulse    = pulse_v[MODE_CH];
    assign bus.sw_out        = lvl_v[SW_LSB +: N_SW];
    assign bus.alu_sel       = alu_sel_q;

    // Sticky selection: lowest-index pulsing button wins, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_sel_q <= ALU_SEL_RESET;
        end else if (|alu_pulse) begin
            alu_sel_q <= lowest_onehot(alu_pulse);
        end
    end

`ifdef INPUT_COND_LONGPRESS_EN
    localparam int unsigned LP_W = (LONGPRESS_CYCLES > 1) ? $clog2(LONGPRESS_CYCLES) : 1;
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONGPRESS_CYCLES - 1);

    logic [LP_W-1:0] lp_cnt;
    logic            lp_hit;
    logic            lp_hit_prev;
    logic            mode_long_q;

    // Saturating hold counter on the debounced mode level; pulse once on reaching the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_cnt      <= '0;
            lp_hit      <= 1'b0;
            lp_hit_prev <= 1'b0;
            mode_long_q <= 1'b0;
        end else begin
            if (!lvl_v[MODE_CH]) begin
                lp_cnt <= '0;
            end else if (lp_cnt != LP_LAST) begin
                lp_cnt <= lp_cnt + LP_W'(1);
            end
            lp_hit      <= (lp_cnt == LP_LAST);
            lp_hit_prev <= lp_hit;
            mode_long_q <= lp_hit & ~lp_hit_prev;
        end
    end

    assign bus.mode_long = mode_long_q;
`else
    // Constant low; the parameter is still referenced so both builds share one port list.
    assign bus.mode_long = 1'b0 & (LONGPRESS_CYCLES == 0);
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (DEBOUNCE_CYCLES=4, LONGPRESS_CYCLES=10).
// Reference model works from the history of raw samples: a level is accepted after
// DEBOUNCE_CYCLES consecutive differing samples, then delayed to the output timing.
// Honours INPUT_COND_LONGPRESS_EN for the mode_long expectation.
module tb_input_conditioner;
    import input_cond_pkg::*;

    localparam int DB   = 4;
    localparam int LP   = 10;
    localparam int MAXE = 8192;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    input_conditioner_if bus ();

    input_conditioner #(
        .DEBOUNCE_CYCLES  (DB),
        .LONGPRESS_CYCLES (LP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state; edge index e counts rising edges since reset release.
    int         e;
    logic [6:0] raw_at [MAXE];
    logic [6:0] q_at   [MAXE];
    int         run_at [MAXE];
    logic [6:0] qm;
    int         diff_run [7];
    logic [3:0] sel_m;
    logic [4:0] p_prev;
    int         lrun;

    function automatic logic [6:0] qa(input int i);
        return (i < 0) ? 7'd0 : q_at[i];
    endfunction

    task automatic model_reset();
        e      = 0;
        qm     = '0;
        for (int c = 0; c < 7; c++) diff_run[c] = 0;
        sel_m  = ALU_SEL_RESET;
        p_prev = '0;
        lrun   = 0;
    endtask

    // Apply one raw vector {sw[1:0], mode, alu[3:0]}, let one edge pass, check all outputs.
    task automatic tick(input logic [6:0] r);
        logic [6:0] s;
        logic [6:0] lvl;
        logic [6:0] pl;
        logic       long_e;
        if (e >= MAXE) begin
            $display("FAIL model_depth: got %0d expected <%0d", e, MAXE);
            $fatal(1, "model history exhausted");
        end
        bus.alu_btn_raw  = r[3:0];
        bus.mode_btn_raw = r[4];
        bus.sw_raw       = r[6:5];
        raw_at[e]        = r;
        @(posedge clk);
        #1;
        // Synchroniser delays the raw sample by two edges.
        s = (e >= 2) ? raw_at[e-2] : 7'd0;
        for (int c = 0; c < 7; c++) begin
            if (s[c] == qm[c]) begin
                diff_run[c] = 0;
            end else begin
                diff_run[c]++;
                if (diff_run[c] == DB) begin
                    qm[c]       = s[c];
                    diff_run[c] = 0;
                end
            end
        end
        q_at[e] = qm;
        lvl = qa(e - 1);
        pl  = qa(e - 2) & ~qa(e - 3);
        if (p_prev[3:0] != 4'd0) begin
            for (int b = 3; b >= 0; b--) if (p_prev[b]) sel_m = 4'b0001 << b;
        end
        p_prev    = pl[4:0];
        lrun      = lvl[4] ? lrun + 1 : 0;
        run_at[e] = lrun;
        long_e    = 1'b0;
`ifdef INPUT_COND_LONGPRESS_EN
        long_e = (e >= 3) && (run_at[e-3] == LP - 1);
`endif
        check("alu_btn_lvl",   32'(bus.alu_btn_lvl),   32'(lvl[3:0]));
        check("alu_btn_pulse", 32'(bus.alu_btn_pulse), 32'(pl[3:0]));
        check("mode_pulse",    32'(bus.mode_pulse),    32'(pl[4]));
        check("sw_out",        32'(bus.sw_out),        32'(lvl[6:5]));
        check("alu_sel",       32'(bus.alu_sel),       32'(sel_m));
        check("mode_long",     32'(bus.mode_long),     32'(long_e));
        e++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lvl"},   32'(bus.alu_btn_lvl),   32'd0);
        check({tag, "_pulse"}, 32'(bus.alu_btn_pulse), 32'd0);
        check({tag, "_sel"},   32'(bus.alu_sel),       32'(ALU_SEL_RESET));
        check({tag, "_mode"},  32'(bus.mode_pulse),    32'd0);
        check({tag, "_long"},  32'(bus.mode_long),     32'd0);
        check({tag, "_sw"},    32'(bus.sw_out),        32'd0);
    endtask

    initial begin
        int lvl_edge, pulse_edge, sel_edge, pcnt, pcnt1, pcnt3, lcnt, long_edge;
        logic [6:0] r;

        rst_n            = 1'b0;
        bus.alu_btn_raw  = '0;
        bus.mode_btn_raw = 1'b0;
        bus.sw_raw       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("init_reset");
        rst_n = 1'b1;
        model_reset();

        // Clean press of SUB from a quiet state.
        lvl_edge = -1; pulse_edge = -1; sel_edge = -1; pcnt = 0;
        for (int k = 0; k < 15; k++) begin
            tick(7'h04);
            if (bus.alu_btn_lvl[2] && lvl_edge < 0) lvl_edge = k;
            if (bus.alu_btn_pulse[2]) begin
                pcnt++;
                if (pulse_edge < 0) pulse_edge = k;
            end
            if (bus.alu_sel == 4'b0100 && sel_edge < 0) sel_edge = k;
        end
        check("press_lvl_edge",   32'(lvl_edge),   32'(DB + 2));
        check("press_pulse_edge", 32'(pulse_edge), 32'(DB + 3));
        check("press_sel_edge",   32'(sel_edge),   32'(DB + 4));
        check("press_pulse_cnt",  32'(pcnt),       32'd1);
        repeat (12) tick(7'h00);

        // Bounce on the mode button shorter than the debounce window.
        pcnt = 0; lcnt = 0;
        foreach (r[i]) r[i] = 1'b0;
        for (int k = 0; k < 14; k++) begin
            r = (k < 4 && (k % 2) == 0) ? 7'h10 : 7'h00;
            tick(r);
            if (bus.mode_pulse) pcnt++;
            if (bus.mode_long)  lcnt++;
        end
        check("bounce_mode_pulse", 32'(pcnt), 32'd0);
        check("bounce_mode_long",  32'(lcnt), 32'd0);

        // AND and ADD pressed together: both pulse, AND wins the selection.
        pcnt1 = 0; pcnt3 = 0;
        for (int k = 0; k < 12; k++) begin
            tick(7'h0A);
            if (bus.alu_btn_pulse[1]) pcnt1++;
            if (bus.alu_btn_pulse[3]) pcnt3++;
        end
        check("simul_pulse_and", 32'(pcnt1), 32'd1);
        check("simul_pulse_add", 32'(pcnt3), 32'd1);
        check("simul_sel",       32'(bus.alu_sel), 32'b0010);
        repeat (12) tick(7'h00);

        // Mode held for 20 cycles.
        pcnt = 0; lcnt = 0; pulse_edge = -1; long_edge = -1;
        for (int k = 0; k < 35; k++) begin
            tick(k < 20 ? 7'h10 : 7'h00);
            if (bus.mode_pulse) begin
                pcnt++;
                if (pulse_edge < 0) pulse_edge = k;
            end
            if (bus.mode_long) begin
                lcnt++;
                if (long_edge < 0) long_edge = k;
            end
        end
        check("long_mode_pulse_cnt", 32'(pcnt), 32'd1);
`ifdef INPUT_COND_LONGPRESS_EN
        check("long_pulse_cnt", 32'(lcnt), 32'd1);
        check("long_gap",       32'(long_edge - pulse_edge), 32'(LP));
`else
        check("long_pulse_cnt", 32'(lcnt), 32'd0);
`endif

        // Randomised activity, biased toward runs long enough to be accepted.
        r = 7'h00;
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < 7; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            tick(r);
        end
        repeat (12) tick(7'h00);

        // OR held through an asynchronous reset asserted mid-cycle.
        repeat (12) tick(7'h01);
        check("pre_reset_lvl", 32'(bus.alu_btn_lvl), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        pcnt = 0; pulse_edge = -1;
        for (int k = 0; k < 20; k++) begin
            tick(7'h01);
            if (bus.alu_btn_pulse[0]) begin
                pcnt++;
                if (pulse_edge < 0) pulse_edge = k;
            end
        end
        check("held_reset_pulse_cnt",  32'(pcnt),       32'd1);
        check("held_reset_pulse_edge", 32'(pulse_edge), 32'(DB + 3));
        repeat (10) tick(7'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
